multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Parametrised multicycle successor to the single-cycle processor datapath. It owns the PC, an instruction register, the register file, the immediate extender, the ALU with registered NZCV flags, and a five-state sequencer. One unified memory port with a ready handshake lets a single memory serve both instruction fetch and data access. The decoded control inputs come combinationally from the existing controller, driven from the `Instr` output.

## Interface
Parameters:
- `WIDTH`, 32: data, address and register width; must be ≥ 32. Instruction fields are always taken from a 32-bit `Instr`.
- `PC_RESET`, 0: PC value after reset.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `RegSrc`  in  2  bit0 selects RA1 = 15; bit1 selects RA2 = `Instr[15:12]` (otherwise `Instr[3:0]`).
- `RegWrite`, `MemWrite`, `MemToReg`, `PCSrc`, `ALUSrc`, `FlagWrite`, `CondEx`  in  1 each  decoded controls.
- `ImmSrc`  in  2  immediate format.
- `ALUControl`  in  2  ALU operation.
- `Instr`  out  32  instruction register.
- `ALUFlags`  out  4  registered NZCV.
- `State`  out  3  sequencer state.
- `MemReq`  out  1  memory request.
- `MemWE`  out  1  memory write enable.
- `MemAddr`, `MemWData`  out  WIDTH  memory address and write data.
- `MemRData`  in  WIDTH  memory read data.
- `MemReady`  in  1  memory completes the request this cycle.
- `CycleCount`, `RetireCount`  out  32  performance counters; see Configuration.

## Operation
- Register file: 15 general registers R0–R14 of WIDTH bits.
  - Two combinational read ports and one write port.
  - Reading index 15 returns PC + 4. The PC has already advanced during fetch, so this equals the instruction address + 8.
- Immediate extension:
  - `ImmSrc` 00: zero-extend `Instr[7:0]`.
  - `ImmSrc` 01: zero-extend `Instr[11:0]`.
  - `ImmSrc` 10: sign-extend `Instr[23:0]`, then shift left by 2.
  - `ImmSrc` 11: zero.
- ALU operations (`ALUControl`): 00 ADD, 01 SUB (A + ~B + 1), 10 AND, 11 ORR. All arithmetic is WIDTH-bit modulo.
- ALU flags:
  - N = result MSB; Z = result is zero.
  - C = carry-out for ADD/SUB, 0 for logic operations.
  - V = signed overflow for ADD/SUB, 0 for logic operations.
- Sequencer states, with encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
  - FETCH: `MemReq`=1, `MemAddr`=PC, `MemWE`=0. Stays in FETCH until `MemReady`. On `MemReady`: `Instr` ← `MemRData[31:0]`, PC ← PC+4, go to DECODE.
  - DECODE: latch A ← RD1 and B ← RD2 (WriteData). Go to EXECUTE.
  - EXECUTE: SrcB = `ALUSrc` ? ExtImm : B; ALUOut ← ALU(A, SrcB).
    - If `CondEx`=0: go to FETCH with no architectural side effect.
    - If `FlagWrite`: update `ALUFlags`.
    - If `MemWrite` or `MemToReg`: go to MEMORY.
    - Else if `PCSrc`: PC ← ALU result, go to FETCH.
    - Else: go to WRITEBACK.
  - MEMORY: `MemReq`=1, `MemAddr`=ALUOut, `MemWE`=`MemWrite`, `MemWData`=B. Wait for `MemReady`.
    - Store completes: go to FETCH.
    - Load completes: Data ← `MemRData`, go to WRITEBACK.
  - WRITEBACK: Result = `MemToReg` ? Data : ALUOut.
    - If `RegWrite` and Rd=`Instr[15:12]`=15: PC ← Result.
    - Else if `RegWrite`: R[Rd] ← Result.
    - Go to FETCH.
- The control inputs are sampled only in the states that use them.

## Timing
- Reset state:
  - PC=`PC_RESET`, `State`=FETCH, `Instr`=0, `ALUFlags`=0, counters=0.
  - `MemReq` is asserted in the first cycle after reset is released.
  - The register file is not reset.
- Unstalled latencies:
  - ALU op: 4 cycles (F, D, E, W).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- While `MemReq` is high without `MemReady`, `MemAddr`, `MemWE` and `MemWData` are held stable.
- `MemReady` is ignored while `MemReq`=0.
- Reset asserted mid-wait: `MemReq`=0 from the cycle after reset is sampled. No register or memory write of the aborted instruction occurs.
- Flags written in EXECUTE are visible on `ALUFlags` the next cycle.
- Register writes are visible to the DECODE of the next instruction.
- PC wraps modulo 2^WIDTH.

## Configuration
- `MULTICYCLE_DP_PERFCNT_EN` defined:
  - `CycleCount` increments every non-reset cycle.
  - `RetireCount` increments on each transition into FETCH from EXECUTE, MEMORY or WRITEBACK where `CondEx`=1 was sampled in EXECUTE.
  - Both counters are 32-bit and wrap to 0.
- Not defined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- ADD R1,R0,#5 with R0=3, `MemReady` always 1 → R1=8 after 4 cycles; `State` sequence 0,1,2,4,0; PC advances by 4.
- SUB with `FlagWrite`, operands 5−5 → `ALUFlags`=0110 (Z=1, C=1); ORR 0x8000_0000|0 with `FlagWrite` → N=1, C=0, V=0.
- LDR with `MemReady` low for 3 memory-phase cycles and `MemRData`=0xDEADBEEF → address held stable; Rd=0xDEADBEEF; total 8 cycles.
- Branch with imm24=0x000002 at PC=0x100 → next fetch address = 0x100+8+8 = 0x110; R15 read in DECODE returns 0x108.
- `CondEx`=0 on a STR → no `MemReq` in a MEMORY state, flags and registers unchanged, next FETCH at PC+4.
- Reset asserted during a FETCH wait → `MemReq`=0 next cycle, PC=`PC_RESET`; with the macro defined, `RetireCount`=0 and `CycleCount` restarts at 0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: PC, IR, register file, immediate extender, NZCV ALU and a five-state
// sequencer on one unified memory port. Optional counters: MULTICYCLE_DP_PERFCNT_EN.
module multicycle_datapath #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       RegSrc,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             MemToReg,
  input  logic             PCSrc,
  input  logic             ALUSrc,
  input  logic             FlagWrite,
  input  logic             CondEx,
  input  logic [1:0]       ImmSrc,
  input  logic [1:0]       ALUControl,
  output logic [31:0]      Instr,
  output logic [3:0]       ALUFlags,
  output logic [2:0]       State,
  output logic             MemReq,
  output logic             MemWE,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic [WIDTH-1:0] MemRData,
  input  logic             MemReady,
  output logic [31:0]      CycleCount,
  output logic [31:0]      RetireCount
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4
  } state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_pc, r_a, r_b, r_alu_out, r_data;
  logic [31:0]      r_instr;
  logic [3:0]       r_flags;
  logic             r_in_reset;
  logic [WIDTH-1:0] r_rf [15];

  logic [3:0]       w_ra1, w_ra2;
  logic [WIDTH-1:0] w_pc_plus4, w_rd1, w_rd2, w_ext_imm, w_srcb, w_b_op, w_result, w_wb_result;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry, w_sub, w_c, w_v, w_mem_done;
  logic [3:0]       w_flags;

  // Register read; index 15 sees the already-advanced PC plus 4.
  assign w_ra1      = RegSrc[0] ? 4'd15 : r_instr[19:16];
  assign w_ra2      = RegSrc[1] ? r_instr[15:12] : r_instr[3:0];
  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_rd1      = (w_ra1 == 4'd15) ? w_pc_plus4 : r_rf[w_ra1];
  assign w_rd2      = (w_ra2 == 4'd15) ? w_pc_plus4 : r_rf[w_ra2];

  always_comb begin
    w_ext_imm = '0;
    unique case (ImmSrc)
      2'b00:   w_ext_imm = {{(WIDTH-8){1'b0}}, r_instr[7:0]};
      2'b01:   w_ext_imm = {{(WIDTH-12){1'b0}}, r_instr[11:0]};
      2'b10:   w_ext_imm = {{(WIDTH-26){r_instr[23]}}, r_instr[23:0], 2'b00};
      default: w_ext_imm = '0;
    endcase
  end

  // SUB is A + ~B + 1, so carry and overflow share the adder with ADD.
  assign w_srcb          = ALUSrc ? w_ext_imm : r_b;
  assign w_sub           = (ALUControl == 2'b01);
  assign w_b_op          = w_sub ? ~w_srcb : w_srcb;
  assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    w_result = w_sum;
    w_c      = 1'b0;
    w_v      = 1'b0;
    unique case (ALUControl)
      2'b00, 2'b01: begin
        w_result = w_sum;
        w_c      = w_carry;
        w_v      = (r_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      2'b10:   w_result = r_a & w_srcb;
      default: w_result = r_a | w_srcb;
    endcase
  end

  assign w_flags     = {w_result[WIDTH-1], (w_result == '0), w_c, w_v};
  assign w_wb_result = MemToReg ? r_data : r_alu_out;

  // Request is suppressed for the cycle following a sampled reset.
  assign MemReq     = !r_in_reset && (r_state == StFetch || r_state == StMemory);
  assign MemWE      = MemReq && (r_state == StMemory) && MemWrite;
  assign MemAddr    = (r_state == StMemory) ? r_alu_out : r_pc;
  assign MemWData   = r_b;
  assign w_mem_done = MemReq && MemReady;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFetch:     if (w_mem_done) w_state_next = StDecode;
      StDecode:    w_state_next = StExecute;
      StExecute: begin
        if (!CondEx)                  w_state_next = StFetch;
        else if (MemWrite || MemToReg) w_state_next = StMemory;
        else if (PCSrc)               w_state_next = StFetch;
        else                          w_state_next = StWriteback;
      end
      StMemory:    if (w_mem_done) w_state_next = MemWrite ? StFetch : StWriteback;
      StWriteback: w_state_next = StFetch;
      default:     w_state_next = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_pc       <= PC_RESET;
      r_instr    <= '0;
      r_flags    <= '0;
      r_in_reset <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_reset <= 1'b0;
      case (r_state)
        StFetch: begin
          if (w_mem_done) begin
            r_instr <= MemRData[31:0];
            r_pc    <= w_pc_plus4;
          end
        end
        StExecute: begin
          if (CondEx) begin
            if (FlagWrite) r_flags <= w_flags;
            if (PCSrc && !MemWrite && !MemToReg) r_pc <= w_result;
          end
        end
        StWriteback: begin
          if (RegWrite && r_instr[15:12] == 4'd15) r_pc <= w_wb_result;
        end
        default: ;
      endcase
    end
  end

  // Datapath latches and register file carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == StDecode) begin
      r_a <= w_rd1;
      r_b <= w_rd2;
    end
    if (r_state == StExecute) r_alu_out <= w_result;
    if (r_state == StMemory && w_mem_done) r_data <= MemRData;
    if (!reset && r_state == StWriteback && RegWrite && r_instr[15:12] != 4'd15) begin
      r_rf[r_instr[15:12]] <= w_wb_result;
    end
  end

  assign Instr    = r_instr;
  assign ALUFlags = r_flags;
  assign State    = r_state;

`ifdef MULTICYCLE_DP_PERFCNT_EN
  logic [31:0] r_cycle_cnt, r_retire_cnt;
  logic        w_retire;

  assign w_retire = (w_state_next == StFetch) &&
                    ((r_state == StExecute && CondEx) || r_state == StMemory ||
                     r_state == StWriteback);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign CycleCount  = r_cycle_cnt;
  assign RetireCount = r_retire_cnt;
`else
  assign CycleCount  = '0;
  assign RetireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: an instruction-level model predicts PC, flags, memory traffic,
// register contents (observed through stores) and per-instruction cycle counts.
module tb_multicycle_datapath;

  localparam logic [31:0] PcReset = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, MemWrite, MemToReg, PCSrc, ALUSrc, FlagWrite, CondEx;
  logic [31:0] Instr, MemAddr, MemWData, MemRData, CycleCount, RetireCount;
  logic [3:0]  ALUFlags;
  logic [2:0]  State;
  logic        MemReq, MemWE, MemReady;

  multicycle_datapath #(.WIDTH(32), .PC_RESET(PcReset)) dut (
    .clk(clk), .reset(reset), .RegSrc(RegSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .FlagWrite(FlagWrite),
    .CondEx(CondEx), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Instr(Instr),
    .ALUFlags(ALUFlags), .State(State), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady), .CycleCount(CycleCount),
    .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] regsrc;
    logic       regwrite, memwrite, memtoreg, pcsrc, alusrc, flagwrite, condex;
    logic [1:0] immsrc, aluctl;
  } ctrl_t;

  int n_pass = 0;
  int n_total = 0;

  // Architectural model
  logic [31:0] m_rf [15];
  logic [31:0] m_pc;
  logic [3:0]  m_flags;
  logic [31:0] m_retire;
  logic [31:0] dmem [logic [31:0]];
  logic [31:0] tb_cyc;

  // Observations of the most recent instruction
  logic [2:0]  seq_q [$];
  int          last_cyc;
  logic [31:0] obs_wd;

  always @(posedge clk) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_counters();
`ifdef MULTICYCLE_DP_PERFCNT_EN
    chk("cycle_count", CycleCount, tb_cyc);
    chk("retire_count", RetireCount, m_retire);
`else
    chk("cycle_count_off", CycleCount, 32'd0);
    chk("retire_count_off", RetireCount, 32'd0);
`endif
  endtask

  function automatic logic [31:0] rreg(input logic [3:0] i);
    return (i == 4'd15) ? m_pc + 32'd8 : m_rf[i];
  endfunction

  function automatic logic [31:0] dread(input logic [31:0] addr);
    return dmem.exists(addr) ? dmem[addr] : (addr ^ 32'h5A5A_1234);
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] rn, input logic [3:0] rd,
                                     input logic [11:0] imm12);
    return {12'hE00, rn, rd, imm12};
  endfunction

  // kind: 0 DP imm, 1 DP reg, 2 STR, 3 LDR, 4 B, 5 ADD from R15
  function automatic ctrl_t ctl(input int kind, input logic [1:0] op, input logic fw);
    ctrl_t c;
    c = '0;
    c.condex = 1'b1;
    c.flagwrite = fw;
    c.aluctl = op;
    case (kind)
      0: begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
      1: c.regwrite = 1'b1;
      2: begin c.regsrc = 2'b10; c.memwrite = 1'b1; c.alusrc = 1'b1; c.immsrc = 2'b01; end
      3: begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.alusrc = 1'b1; c.immsrc = 2'b01; end
      4: begin c.regsrc = 2'b01; c.pcsrc = 1'b1; c.alusrc = 1'b1; c.immsrc = 2'b10; end
      default: begin
        c.regsrc = 2'b01; c.regwrite = 1'b1; c.alusrc = 1'b1; c.immsrc = 2'b01;
      end
    endcase
    return c;
  endfunction

  // Runs one instruction; entered and left at a negedge with the DUT in FETCH.
  task automatic exec(input logic [31:0] iw, input ctrl_t c, input int wf, input int wm);
    logic [3:0]  ra1, ra2, rd;
    logic [31:0] a, b, imm, srcb, res, ldv, nxt_pc, wb, m_addr, m_wd;
    logic [3:0]  fl;
    logic        cf, vf, m_we;
    longint      sr;
    longint unsigned ur;
    int          s24, exp_cyc, cyc, fw, mw, mem_cyc;
    bit          exp_mem, left, done, stable;

    ra1 = c.regsrc[0] ? 4'd15 : iw[19:16];
    ra2 = c.regsrc[1] ? iw[15:12] : iw[3:0];
    rd  = iw[15:12];
    a   = rreg(ra1);
    b   = rreg(ra2);
    case (c.immsrc)
      2'd0: imm = {24'd0, iw[7:0]};
      2'd1: imm = {20'd0, iw[11:0]};
      2'd2: begin s24 = int'($signed(iw[23:0])); imm = 32'(s24 * 4); end
      default: imm = 32'd0;
    endcase
    srcb = c.alusrc ? imm : b;
    cf = 1'b0;
    vf = 1'b0;
    case (c.aluctl)
      2'd0: begin
        res = a + srcb;
        ur  = 64'(a) + 64'(srcb);
        cf  = (ur > 64'hFFFF_FFFF);
        sr  = longint'($signed(a)) + longint'($signed(srcb));
        vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd1: begin
        res = a - srcb;
        cf  = (a >= srcb);
        sr  = longint'($signed(a)) - longint'($signed(srcb));
        vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'd2: res = a & srcb;
      default: res = a | srcb;
    endcase
    fl = {res[31], res == 32'd0, cf, vf};

    nxt_pc  = m_pc + 32'd4;
    exp_mem = 1'b0;
    ldv     = dread(res);
    if (!c.condex) exp_cyc = 3;
    else if (c.memwrite) begin exp_mem = 1'b1; exp_cyc = 4; end
    else if (c.memtoreg) begin exp_mem = 1'b1; exp_cyc = 5; end
    else if (c.pcsrc) begin exp_cyc = 3; nxt_pc = res; end
    else exp_cyc = 4;
    exp_cyc += wf + (exp_mem ? wm : 0);

    {RegSrc, RegWrite, MemWrite, MemToReg, PCSrc, ALUSrc, FlagWrite, CondEx, ImmSrc,
     ALUControl} = c;

    chk("fetch_req", 32'(MemReq), 32'd1);
    chk("fetch_addr", MemAddr, m_pc);

    cyc = 0; fw = 0; mw = 0; mem_cyc = 0;
    left = 1'b0; done = 1'b0; stable = 1'b1;
    m_addr = '0; m_wd = '0; m_we = 1'b0;
    seq_q.delete();
    while (!done && cyc < 64) begin
      seq_q.push_back(State);
      MemReady = 1'($urandom);
      MemRData = $urandom;
      if (MemReq && State == 3'd0) begin
        if (fw < wf) begin fw++; MemReady = 1'b0; end
        else begin MemReady = 1'b1; MemRData = iw; end
      end else if (MemReq && State == 3'd3) begin
        if (mem_cyc == 0) begin
          m_addr = MemAddr; m_we = MemWE; m_wd = MemWData;
        end else if (MemAddr !== m_addr || MemWE !== m_we || MemWData !== m_wd) begin
          stable = 1'b0;
        end
        mem_cyc++;
        if (mw < wm) begin mw++; MemReady = 1'b0; end
        else begin MemReady = 1'b1; MemRData = ldv; end
      end
      @(negedge clk);
      cyc++;
      if (State != 3'd0) left = 1'b1;
      else if (left) done = 1'b1;
    end
    MemReady = 1'b0;
    last_cyc = cyc;
    obs_wd   = m_wd;

    // Commit architectural effects
    if (c.condex) begin
      if (c.flagwrite) m_flags = fl;
      if (c.memwrite) dmem[res] = b;
      else if (!c.pcsrc || c.memtoreg) begin
        wb = c.memtoreg ? ldv : res;
        if (c.regwrite) begin
          if (rd == 4'd15) nxt_pc = wb;
          else m_rf[rd] = wb;
        end
      end
      m_retire = m_retire + 32'd1;
    end
    m_pc = nxt_pc;

    chk("completed", 32'(done), 32'd1);
    chk("cycles", 32'(cyc), 32'(exp_cyc));
    chk("instr", Instr, iw);
    chk("flags", 32'(ALUFlags), 32'(m_flags));
    chk("mem_phase", 32'(mem_cyc != 0), 32'(exp_mem));
    if (exp_mem) begin
      chk("mem_addr", m_addr, res);
      chk("mem_we", 32'(m_we), 32'(c.memwrite));
      chk("mem_stable", 32'(stable), 32'd1);
      if (c.memwrite) chk("mem_wdata", m_wd, b);
    end
    chk_counters();
  endtask

  initial begin
    ctrl_t c;
    logic [31:0] iw, pc_before;
    int k;

    reset = 1'b1;
    {RegSrc, RegWrite, MemWrite, MemToReg, PCSrc, ALUSrc, FlagWrite, CondEx, ImmSrc,
     ALUControl} = '0;
    MemReady = 1'b0;
    MemRData = '0;
    m_pc = PcReset;
    m_flags = '0;
    m_retire = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_flags", 32'(ALUFlags), 32'd0);
    chk("rst_pc", MemAddr, PcReset);
    chk_counters();
    reset = 1'b0;
    @(negedge clk);

    // Branch with imm24 = 2 from 0x100
    exec(32'hEA00_0002, ctl(4, 2'd0, 1'b0), 0, 0);
    chk("branch_target", MemAddr, 32'h0000_0110);
    chk("branch_cycles", 32'(last_cyc), 32'd3);

    // R0 = 0, R0 = 3, R1 = R0 + 5
    exec(mk(4'd15, 4'd0, 12'h000), ctl(0, 2'd2, 1'b0), 0, 0);
    exec(mk(4'd0, 4'd0, 12'h003), ctl(0, 2'd0, 1'b0), 1, 0);
    pc_before = m_pc;
    exec(mk(4'd0, 4'd1, 12'h005), ctl(0, 2'd0, 1'b0), 0, 0);
    chk("add_seq_len", 32'(seq_q.size()), 32'd4);
    chk("add_seq", {20'd0, seq_q[0], seq_q[1], seq_q[2], seq_q[3]},
        {20'd0, 3'd0, 3'd1, 3'd2, 3'd4});
    chk("add_pc_step", MemAddr, pc_before + 32'd4);
    exec(mk(4'd0, 4'd1, 12'h040), ctl(2, 2'd0, 1'b0), 0, 1);
    chk("add_result", obs_wd, 32'd8);

    // 5 - 5 with flags, then 0x8000_0000 | 0
    exec(mk(4'd0, 4'd2, 12'h002), ctl(0, 2'd0, 1'b0), 0, 0);
    exec(mk(4'd2, 4'd3, 12'h002), ctl(1, 2'd1, 1'b1), 0, 0);
    chk("sub_flags", 32'(ALUFlags), 32'b0110);
    dmem[32'h200] = 32'h8000_0000;
    exec(mk(4'd0, 4'd4, 12'h1FD), ctl(3, 2'd0, 1'b0), 0, 0);
    exec(mk(4'd4, 4'd5, 12'h000), ctl(0, 2'd3, 1'b1), 0, 0);
    chk("orr_flags", 32'(ALUFlags), 32'b1000);

    // Load with three memory wait cycles
    dmem[32'h300] = 32'hDEAD_BEEF;
    exec(mk(4'd0, 4'd6, 12'h2FD), ctl(3, 2'd0, 1'b0), 0, 3);
    chk("ldr_cycles", 32'(last_cyc), 32'd8);
    exec(mk(4'd0, 4'd6, 12'h010), ctl(2, 2'd0, 1'b0), 0, 0);
    chk("ldr_result", obs_wd, 32'hDEAD_BEEF);

    // Condition-failed store
    c = ctl(2, 2'd0, 1'b1);
    c.condex = 1'b0;
    pc_before = m_pc;
    exec(mk(4'd0, 4'd1, 12'h080), c, 0, 0);
    chk("condfail_next", MemAddr, pc_before + 32'd4);
    chk("condfail_flags", 32'(ALUFlags), 32'b1000);

    // Initialise all registers, then random instruction mix
    for (int n = 0; n < 15; n++) begin
      exec(mk(4'd15, 4'(n), 12'($urandom)), ctl(5, 2'd0, 1'b0), 0, 0);
    end
    for (int i = 0; i < 80; i++) begin
      iw = $urandom;
      k = $urandom_range(0, 4);
      c = ctl(k, 2'($urandom), 1'($urandom));
      if (k == 0) c.immsrc = 2'($urandom);
      if (k == 2 || k == 3) c.aluctl = {1'b0, 1'($urandom)};
      if (k == 4) c.aluctl = 2'd0;
      c.condex = ($urandom_range(0, 7) != 0);
      exec(iw, c, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int n = 0; n < 15; n++) begin
      exec(mk(4'd15, 4'(n), 12'($urandom)), ctl(2, 2'd0, 1'b0), 0, 0);
    end

    // Reset during a stalled fetch
    MemReady = 1'b0;
    @(negedge clk);
    chk("stall_state", 32'(State), 32'd0);
    chk("stall_req", 32'(MemReq), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    m_pc = PcReset;
    m_flags = '0;
    m_retire = '0;
    chk("midrst_memreq", 32'(MemReq), 32'd0);
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_pc", MemAddr, PcReset);
    chk("midrst_flags", 32'(ALUFlags), 32'd0);
    chk_counters();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(MemReq), 32'd1);
    exec(mk(4'd0, 4'd7, 12'h000), ctl(2, 2'd0, 1'b0), 2, 1);
    exec(mk(4'd7, 4'd8, 12'h123), ctl(0, 2'd0, 1'b1), 0, 0);
    exec(mk(4'd0, 4'd8, 12'h004), ctl(2, 2'd0, 1'b0), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
